song_sequencer: RTL
===================

# song_sequencer

Parametrised successor to the single-voice song reader. It walks a song ROM and dispatches notes to a bank of VOICES note players, picking the lowest-index free voice. It counts rests against the beat strobe and handles end-of-song markers, song changes and pause/resume mid-rest. It sits between the song ROM and the note-player bank, and is driven by the top-level play/song controls.

## Interface
Parameters:
- SONG_BITS, 2: song select width
- NOTE_ADDR_BITS, 5: per-song note address width
- VOICES, 2: number of note players (≥1); VOICE_BITS = max(1, clog2(VOICES))
- NOTE_BITS, 6 / DUR_BITS, 6 / META_BITS, 3: ROM field widths

Ports:
- clk  in  1  single clock; all state on its rising edge
- reset  in  1  asynchronous, active-low reset
- play  in  1  level; low = pause
- song  in  SONG_BITS  song select
- beat  in  1  one-cycle beat strobe
- voice_busy  in  VOICES  per-voice busy level
- rom_addr  out  SONG_BITS+NOTE_ADDR_BITS  = {song_q, note_addr}, combinational from registers
- rom_data  in  1+NOTE_BITS+DUR_BITS+META_BITS  {type, note, duration, metadata}; valid one cycle after rom_addr
- new_note  out  1  one-cycle registered pulse
- voice_sel  out  VOICE_BITS  target voice, qualified by new_note
- note, duration, metadata  out  field widths  registered, hold last issued values
- song_done  out  1  registered level

## Operation
- ROM word decode:
  - type=0: note.
  - type=1: rest; the note field gives the rest length in beats.
  - type=0 with duration=0: end marker.
- States: IDLE, FETCH, WAIT, ISSUE, REST, DONE.
- IDLE: play → FETCH; otherwise hold. note_addr is preserved.
- FETCH: rom_addr is presented. → WAIT.
- WAIT: latch rom_data, then branch:
  - end marker → DONE
  - rest → REST, loading rest_cnt = note field
  - note → ISSUE
- ISSUE: if play and some voice_busy bit is 0:
  - register new_note=1, voice_sel = lowest free index, and the fields
  - note_addr+1, → FETCH
  - if play is low → IDLE, with no issue and no increment
  - if all voices are busy → stay in ISSUE (stall)
- REST: beat is counted only in REST, and only while play=1. rest_cnt==0 → note_addr+1, → FETCH. A rest of length 0 therefore takes zero beats. While play=0 the state stays REST and the count is frozen.
- Address wrap: if the word at the maximum note_addr is not an end marker, its processing completes and then the FSM goes to DONE instead of incrementing.
- DONE: song_done=1. The FSM stays here until a song change.
- Song change (song ≠ song_q), in any state:
  - song_q ← song, note_addr ← 0, song_done ← 0, → IDLE
  - a pending ISSUE is dropped
  - takes priority over every other transition in the same cycle
- Voices must raise voice_busy no later than the cycle after their new_note.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, note_addr=0, song_q=0, rest_cnt=0
  - new_note=0, voice_sel=0, note=0, duration=0, metadata=0, song_done=0
- play sampled high in IDLE at edge 0: FETCH after edge 0, WAIT after edge 1, ISSUE after edge 2. new_note is high during the cycle after edge 3.
- Sustained throughput: one note per 3 cycles when a voice is free.
- Rest of N beats: exit REST on the edge sampling the Nth beat, then 3 cycles to the next new_note.
- new_note is never high in consecutive cycles.

## Configuration
- SONG_LOOP_EN defined:
  - an end marker or address wrap sets note_addr=0 and goes → FETCH, not DONE
  - song_done pulses for exactly one cycle on each loop
- SONG_LOOP_EN undefined: behaviour is as specified above (DONE, song_done held as a level).

## Structure
- song_pkg holds:
  - state encoding constants
  - ROM word field offsets and widths
  - the end-marker predicate
- Sub-module rest_timer holds rest_cnt:
  - load, beat, enable and zero-flag ports
  - NOTE_BITS wide
- Free-voice selection is a combinational priority encoder inside song_sequencer.

## Test plan
- Song 0 ROM = [note 12 dur 8, note 15 dur 8, end], VOICES=2, voices idle, play=1. Expect:
  - new_note pulses 3 cycles apart: (voice 0, note 12), then (voice 0, note 15) if busy was not raised, or voice 1 if voice 0 is busy
  - song_done=1 after the end marker
- Rest of 4 beats with play dropped after 2 beats for 20 cycles:
  - no advance while paused
  - the next new_note arrives 3 cycles after the 4th counted beat following resume
- All voice_busy=1 while in ISSUE for 10 cycles: no new_note. Release voice 1 → one pulse with voice_sel=1.
- Song switched from 0 to 2 mid-REST: rom_addr = {2, 0}, state IDLE, song_done=0, rest discarded.
- Last address (31) holds a note with no end marker:
  - without SONG_LOOP_EN: note issued, then song_done=1 held
  - with SONG_LOOP_EN: one-cycle song_done and refetch from address 0
- reset asserted mid-ISSUE: all outputs 0 immediately and asynchronously; no new_note follows.

Source files
------------

// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared constants and helpers for the song sequencer
//
// Holds the sequencer state encoding, the ROM word layout and the
// end-marker predicate. The ROM word is {type, note, duration, metadata}
// with metadata in the least significant bits.
package song_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_REST  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic TYPE_NOTE = 1'b0;
    localparam logic TYPE_REST = 1'b1;

    localparam int META_LSB = 0;

    function automatic int dur_lsb(input int meta_bits);
        return meta_bits;
    endfunction

    function automatic int note_lsb(input int meta_bits, input int dur_bits);
        return meta_bits + dur_bits;
    endfunction

    function automatic int type_pos(input int meta_bits, input int dur_bits, input int note_bits);
        return meta_bits + dur_bits + note_bits;
    endfunction

    // A note word with zero duration terminates the song.
    function automatic logic is_end_marker(input logic word_type, input logic dur_zero);
        return (word_type == TYPE_NOTE) && dur_zero;
    endfunction

endpackage

// File: rtl/rest_timer.sv
// rtl/rest_timer.sv - beat-counting rest timer for the song sequencer
//
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   load         load rest_cnt from load_val (wins over counting)
//   load_val     rest length in beats
//   beat         one-cycle beat strobe
//   enable       counting allowed (sequencer resting and playing)
//   zero         rest is over as seen this cycle
module rest_timer
    import song_pkg::*;
#(
    parameter int NOTE_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [NOTE_BITS-1:0] load_val,
    input  logic                 beat,
    input  logic                 enable,
    output logic                 zero
);

    logic [NOTE_BITS-1:0] rest_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rest_cnt <= '0;
        end else if (load) begin
            rest_cnt <= load_val;
        end else if (enable && beat && (rest_cnt != '0)) begin
            rest_cnt <= rest_cnt - NOTE_BITS'(1);
        end
    end

    // Also flags the beat that consumes the last remaining count, so the
    // sequencer leaves the rest on the same edge that samples the final beat.
    assign zero = (rest_cnt == '0) ||
                  (enable && beat && (rest_cnt == NOTE_BITS'(1)));

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - song ROM walker dispatching notes to a voice bank
//
// Optional feature macro: SONG_LOOP_EN (end of song restarts at address 0
// and song_done becomes a one-cycle pulse per loop).
//
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   play         level, low pauses
//   song         song select; any change restarts at address 0 in IDLE
//   beat         one-cycle beat strobe used to time rests
//   voice_busy   per-voice busy level
//   rom_addr     {song_q, note_addr}, ROM data returns one cycle later
//   rom_data     {type, note, duration, metadata}
//   new_note     one-cycle issue pulse, qualifies voice_sel
//   voice_sel    lowest-index free voice at issue time
//   note, duration, metadata   last issued fields
//   song_done    end of song reached
module song_sequencer
    import song_pkg::*;
#(
    parameter int  SONG_BITS      = 2,
    parameter int  NOTE_ADDR_BITS = 5,
    parameter int  VOICES         = 2,
    parameter int  NOTE_BITS      = 6,
    parameter int  DUR_BITS       = 6,
    parameter int  META_BITS      = 3,
    localparam int VOICE_BITS     = (VOICES > 1) ? $clog2(VOICES) : 1,
    localparam int WORD_BITS      = 1 + NOTE_BITS + DUR_BITS + META_BITS
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                play,
    input  logic [SONG_BITS-1:0]                song,
    input  logic                                beat,
    input  logic [VOICES-1:0]                   voice_busy,
    output logic [SONG_BITS+NOTE_ADDR_BITS-1:0] rom_addr,
    input  logic [WORD_BITS-1:0]                rom_data,
    output logic                                new_note,
    output logic [VOICE_BITS-1:0]               voice_sel,
    output logic [NOTE_BITS-1:0]                note,
    output logic [DUR_BITS-1:0]                 duration,
    output logic [META_BITS-1:0]                metadata,
    output logic                                song_done
);

    localparam int DUR_LSB  = dur_lsb(META_BITS);
    localparam int NOTE_LSB = note_lsb(META_BITS, DUR_BITS);
    localparam int TYPE_POS = type_pos(META_BITS, DUR_BITS, NOTE_BITS);

    logic [2:0]                state, state_d;
    logic [NOTE_ADDR_BITS-1:0] note_addr, addr_d;
    logic [SONG_BITS-1:0]      song_q;
    logic [NOTE_BITS-1:0]      wd_note;
    logic [DUR_BITS-1:0]       wd_dur;
    logic [META_BITS-1:0]      wd_meta;

    logic                  rom_type;
    logic [NOTE_BITS-1:0]  rom_note;
    logic [DUR_BITS-1:0]   rom_dur;
    logic [META_BITS-1:0]  rom_meta;
    logic                  rom_end;

    logic                  song_chg;
    logic                  at_last;
    logic                  any_free;
    logic [VOICE_BITS-1:0] free_idx;
    logic                  rest_load;
    logic                  rest_zero;
    logic                  latch_word;
    logic                  issue;
    logic                  advance;
    logic                  finish;

    assign rom_type = rom_data[TYPE_POS];
    assign rom_note = rom_data[NOTE_LSB +: NOTE_BITS];
    assign rom_dur  = rom_data[DUR_LSB +: DUR_BITS];
    assign rom_meta = rom_data[META_LSB +: META_BITS];
    assign rom_end  = is_end_marker(rom_type, rom_dur == '0);

    assign rom_addr = {song_q, note_addr};
    assign song_chg = (song != song_q);
    assign at_last  = &note_addr;

    // Scan from the top so the lowest free index is the one left standing.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (!voice_busy[i]) begin
                any_free = 1'b1;
                free_idx = VOICE_BITS'(i);
            end
        end
    end

    // A song change also clears the rest count so nothing of the old rest
    // survives into the new song.
    assign rest_load = song_chg ||
                       ((state == S_WAIT) && !rom_end && (rom_type == TYPE_REST));

    rest_timer #(
        .NOTE_BITS(NOTE_BITS)
    ) u_rest_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (rest_load),
        .load_val (song_chg ? '0 : rom_note),
        .beat     (beat),
        .enable   ((state == S_REST) && play),
        .zero     (rest_zero)
    );

    always_comb begin
        state_d    = state;
        addr_d     = note_addr;
        latch_word = 1'b0;
        issue      = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;

        case (state)
            S_IDLE:  if (play) state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                latch_word = 1'b1;
                if (rom_end)                    finish  = 1'b1;
                else if (rom_type == TYPE_REST) state_d = S_REST;
                else                            state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!play) begin
                    state_d = S_IDLE;
                end else if (any_free) begin
                    issue   = 1'b1;
                    advance = 1'b1;
                end
            end
            S_REST:  if (play && rest_zero) advance = 1'b1;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // The last address has no successor: finishing it ends the song.
        if (advance) begin
            if (at_last) begin
                finish = 1'b1;
            end else begin
                addr_d  = note_addr + NOTE_ADDR_BITS'(1);
                state_d = S_FETCH;
            end
        end

        if (finish) begin
`ifdef SONG_LOOP_EN
            addr_d  = '0;
            state_d = S_FETCH;
`else
            state_d = S_DONE;
`endif
        end

        if (song_chg) begin
            state_d    = S_IDLE;
            addr_d     = '0;
            latch_word = 1'b0;
            issue      = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            note_addr <= '0;
            song_q    <= '0;
            wd_note   <= '0;
            wd_dur    <= '0;
            wd_meta   <= '0;
            new_note  <= 1'b0;
            voice_sel <= '0;
            note      <= '0;
            duration  <= '0;
            metadata  <= '0;
            song_done <= 1'b0;
        end else begin
            state     <= state_d;
            note_addr <= addr_d;
            song_q    <= song;
            new_note  <= issue;
            if (latch_word) begin
                wd_note <= rom_note;
                wd_dur  <= rom_dur;
                wd_meta <= rom_meta;
            end
            if (issue) begin
                voice_sel <= free_idx;
                note      <= wd_note;
                duration  <= wd_dur;
                metadata  <= wd_meta;
            end
`ifdef SONG_LOOP_EN
            song_done <= finish;
`else
            if (song_chg)    song_done <= 1'b0;
            else if (finish) song_done <= 1'b1;
`endif
        end
    end

endmodule
